// File: rtl/dcache_direct_mapped_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_direct_mapped_if
// Brief    : Core-side request port and 128-bit memory port of the D-cache.
// Revision : 1.0  initial release
// ============================================================================
interface dcache_direct_mapped_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    // Cache view: answers the core, drives the memory port
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment view: the core plus main memory
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : dcache_direct_mapped
// Brief    : Direct-mapped, write-back, write-allocate data cache, 4-word lines.
// Revision : 1.0  initial release
// ============================================================================
module dcache_direct_mapped #(
    parameter int NUM_BLOCKS = 8
) (
    input  wire logic             clk,
    input  wire logic             proc_reset,
    dcache_direct_mapped_if.slave bus
);
    localparam int c_IDX_W = $clog2(NUM_BLOCKS);
    localparam int c_TAG_W = 28 - c_IDX_W;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ALLOCATE  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [c_TAG_W-1:0]    r_tag  [NUM_BLOCKS];
    logic [127:0]          r_data [NUM_BLOCKS];

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic [1:0]         w_word;
    logic               w_req;
    logic               w_hit;
    logic               w_wr_hit;
    logic               w_fill;
    logic [127:0]       w_line;

    assign w_idx    = bus.proc_addr[c_IDX_W+1:2];
    assign w_tag    = bus.proc_addr[29:c_IDX_W+2];
    assign w_word   = bus.proc_addr[1:0];
    assign w_req    = bus.proc_read | bus.proc_write;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A simultaneous read+write is a store; the merge waits for the post-fill hit cycle
    assign w_wr_hit = (r_state == c_IDLE) && bus.proc_write && w_hit;
    assign w_fill   = (r_state == c_ALLOCATE) && bus.mem_ready;
    assign w_line   = r_data[w_idx];

    assign bus.proc_rdata = w_line[{w_word, 5'b00000} +: 32];

    always_comb begin
        bus.proc_stall = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 28'd0;
        bus.mem_wdata  = 128'd0;
        case (r_state)
            c_IDLE: begin
                bus.proc_stall = w_req & ~w_hit;
            end
            c_WRITEBACK: begin
                bus.proc_stall = 1'b1;
                bus.mem_write  = 1'b1;
                bus.mem_addr   = {r_tag[w_idx], w_idx};
                bus.mem_wdata  = r_data[w_idx];
            end
            c_ALLOCATE: begin
                bus.proc_stall = 1'b1;
                bus.mem_read   = 1'b1;
                bus.mem_addr   = bus.proc_addr[29:2];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req && !w_hit)
                    w_state_nxt = r_dirty[w_idx] ? c_WRITEBACK : c_ALLOCATE;
            end
            c_WRITEBACK: begin
                if (bus.mem_ready)
                    w_state_nxt = c_ALLOCATE;
            end
            c_ALLOCATE: begin
                if (bus.mem_ready)
                    w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= c_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_hit)
                r_dirty[w_idx] <= 1'b1;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            if (w_wr_hit)
                r_data[w_idx][{w_word, 5'b00000} +: 32] <= bus.proc_wdata;
            if (w_fill) begin
                r_data[w_idx] <= bus.mem_rdata;
                r_tag[w_idx]  <= w_tag;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_direct_mapped
// Brief    : Directed and random bench for dcache_direct_mapped vs. flat memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_dcache_direct_mapped;
    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    dcache_direct_mapped_if bus();

    dcache_direct_mapped #(.NUM_BLOCKS(8)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus.slave)
    );

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } xact_t;

    xact_t        log_q [$];
    logic [127:0] mem_lines [logic [27:0]];
    logic [31:0]  ref_mem   [logic [29:0]];
    int           lat_min = 1;
    int           lat_max = 1;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           both_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return 32'(a) * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [127:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int w = 0; w < 4; w++)
            l[w*32 +: 32] = init_word({la, 2'(w)});
        return l;
    endfunction

    // What a load must return: latest store, else whatever main memory holds
    function automatic logic [31:0] ref_word(input logic [29:0] a);
        logic [127:0] l;
        if (ref_mem.exists(a)) return ref_mem[a];
        l = mem_line(a[29:2]);
        return l[a[1:0]*32 +: 32];
    endfunction

    // Main memory: latency counted in cycles the request is visible
    initial begin
        xact_t x;
        int    lat;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        forever begin
            if (bus.mem_read || bus.mem_write) begin
                x.wr   = bus.mem_write;
                x.addr = bus.mem_addr;
                x.data = bus.mem_wdata;
                lat = $urandom_range(lat_max, lat_min);
                repeat (lat - 1) @(negedge clk);
                if (x.wr) mem_lines[x.addr] = x.data;
                else      bus.mem_rdata = mem_line(x.addr);
                log_q.push_back(x);
                bus.mem_ready = 1'b1;
                @(negedge clk);
                bus.mem_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    always @(negedge clk)
        if (bus.mem_read && bus.mem_write) both_cnt++;

    task automatic do_op(input bit rd, input bit wr, input logic [29:0] a,
                         input logic [31:0] wd, output logic [31:0] rdat, output int stalls);
        @(negedge clk);
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        #1;
        stalls = 0;
        while (bus.proc_stall && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (bus.proc_stall) chk("op_timeout", 1, 0);
        rdat = bus.proc_rdata;
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    logic [31:0] rd;
    int          st;
    int          r;
    logic [29:0] ra;
    logic [31:0] rw;

    initial begin
        proc_reset     = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        #1;
        chk("rst_stall", bus.proc_stall, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);

        // Clean read miss, then store/load hits on the same line
        lat_min = 2; lat_max = 2;
        log_q.delete();
        do_op(1, 0, 30'h10, 0, rd, st);
        chk("t1_stalls", st, 3);
        chk("t1_rdata", rd, ref_word(30'h10));
        chk("t1_nx", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t1_kind", log_q[0].wr, 0);
            chk("t1_addr", log_q[0].addr, 28'h4);
        end
        do_op(0, 1, 30'h11, 32'hDEADBEEF, rd, st);
        ref_mem[30'h11] = 32'hDEADBEEF;
        chk("t2_wr_stalls", st, 0);
        do_op(1, 0, 30'h11, 0, rd, st);
        chk("t2_rd_stalls", st, 0);
        chk("t2_rdata", rd, 32'hDEADBEEF);

        // Conflicting tag on a dirty line: write-back then fill
        log_q.delete();
        do_op(1, 0, 30'h110, 0, rd, st);
        chk("t3_stalls", st, 5);
        chk("t3_rdata", rd, ref_word(30'h110));
        chk("t3_nx", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t3_wb_kind", log_q[0].wr, 1);
            chk("t3_wb_addr", log_q[0].addr, 28'h4);
            chk("t3_wb_word1", log_q[0].data[63:32], 32'hDEADBEEF);
            chk("t3_wb_word0", log_q[0].data[31:0], init_word(30'h10));
            chk("t3_fill_kind", log_q[1].wr, 0);
            chk("t3_fill_addr", log_q[1].addr, 28'h44);
        end

        // Write miss on a clean line: allocate only, merge after fill
        log_q.delete();
        do_op(0, 1, 30'h23, 32'hCAFE0123, rd, st);
        ref_mem[30'h23] = 32'hCAFE0123;
        chk("t4_stalls", st, 3);
        chk("t4_nx", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t4_kind", log_q[0].wr, 0);
            chk("t4_addr", log_q[0].addr, 28'h8);
        end
        do_op(1, 0, 30'h23, 0, rd, st);
        chk("t4_rd_stalls", st, 0);
        chk("t4_rdata", rd, 32'hCAFE0123);
        log_q.delete();
        do_op(1, 0, 30'h03, 0, rd, st);
        chk("t4_evict_stalls", st, 5);
        chk("t4_rd03", rd, ref_word(30'h03));
        if (log_q.size() >= 1)
            chk("t4_wb_word3", log_q[0].data[127:96], 32'hCAFE0123);
        else
            chk("t4_wb_seen", 0, 1);
        // Dirty line whose data the coming reset must discard
        do_op(0, 1, 30'h03, 32'h11112222, rd, st);
        chk("t4_dirty_stalls", st, 0);

        // Reset in the middle of a fill
        lat_min = 3; lat_max = 3;
        @(negedge clk);
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h50;
        #1;
        chk("t5_miss_stall", bus.proc_stall, 1);
        @(negedge clk);
        #1;
        chk("t5_alloc_read", bus.mem_read, 1);
        chk("t5_alloc_addr", bus.mem_addr, 28'h14);
        proc_reset    = 1'b1;
        bus.proc_read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        #1;
        chk("t5_read_drop", bus.mem_read, 0);
        chk("t5_write_low", bus.mem_write, 0);
        chk("t5_stall_low", bus.proc_stall, 0);
        ref_mem.delete();
        idle_cycles(5);
        chk("t5_idle_read", bus.mem_read, 0);
        do_op(1, 0, 30'h03, 0, rd, st);
        chk("t5_reread_stalls", st, 4);
        chk("t5_reread_data", rd, init_word(30'h03));
        do_op(1, 0, 30'h11, 0, rd, st);
        chk("t5_rd11_stalls", st, 4);
        chk("t5_rd11_data", rd, 32'hDEADBEEF);

        // Random traffic against the flat-memory reference
        lat_min = 1; lat_max = 8;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(9, 0);
            ra = 30'($urandom_range(127, 0));
            rw = $urandom;
            if (r < 4) begin
                do_op(1, 0, ra, rw, rd, st);
                chk("rnd_load", rd, ref_word(ra));
            end else if (r < 9) begin
                do_op(r == 8, 1, ra, rw, rd, st);
                ref_mem[ra] = rw;
            end else begin
                idle_cycles(1);
            end
        end
        idle_cycles(2);
        chk("rw_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
